// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: one-entry sample buffer feeding a shifter that emits
// standard I2S frames. Define I2S_TX_UNDERFLOW_CNT_EN to add a saturating underflow counter.
module i2s_tx_serializer (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cfg_en_i,
    input  logic [4:0]  cfg_word_len_i,
    input  logic        cfg_lsb_first_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        sd_o,
    output logic        ws_o,
    output logic        underflow_o,
    output logic        busy_o
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_cnt_o
`endif
);

    // Sample handshake: a sample transfers on a rising clk_i edge where
    // valid_i && ready_o; ready_o is high only while the buffer is empty and
    // the transmitter is not idle, and valid_i may be withdrawn at any time.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [4:0]  r_len;
    logic        r_lsb;
    logic [31:0] r_shift;
    logic [31:0] r_buf;
    logic        r_buf_valid;

    logic        w_hs;
    logic        w_active;
    logic        w_stop;
    logic        w_load;
    logic        w_relatch;
    logic [4:0]  w_len_cfg;
    logic [4:0]  w_len;
    logic        w_lsb;
    logic [31:0] w_load_data;
    logic        w_first_bit;
    logic        w_buf_valid_nxt;

    assign w_hs      = valid_i && ready_o;
    assign w_active  = (r_state != ST_IDLE);
    assign w_len_cfg = (cfg_word_len_i < 5'd7) ? 5'd7 : cfg_word_len_i;

    // cnt==0 with ws_o==0 means the right slot just finished its last bit.
    assign w_stop    = (r_state == ST_DRAIN) && !cfg_en_i && (r_cnt == 5'd0) && !ws_o;
    assign w_load    = w_active && !w_stop && (r_cnt == 5'd0);

    // The format only changes at the start of a left slot (frame boundary).
    assign w_relatch   = w_load && !ws_o;
    assign w_len       = w_relatch ? w_len_cfg : r_len;
    assign w_lsb       = w_relatch ? cfg_lsb_first_i : r_lsb;
    assign w_load_data = r_buf_valid ? r_buf : 32'd0;
    assign w_first_bit = w_lsb ? w_load_data[0] : w_load_data[w_len];

    always_comb begin
        w_buf_valid_nxt = r_buf_valid;
        if (!w_active || w_stop) begin
            w_buf_valid_nxt = 1'b0;
        end else if (w_load) begin
            w_buf_valid_nxt = w_hs;
        end else if (w_hs) begin
            w_buf_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_buf_valid <= 1'b0;
            r_buf       <= 32'd0;
        end else begin
            r_buf_valid <= w_buf_valid_nxt;
            if (w_hs) begin
                r_buf <= data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 5'd0;
            r_shift     <= 32'd0;
            r_len       <= 5'd7;
            r_lsb       <= 1'b0;
            sd_o        <= 1'b0;
            ws_o        <= 1'b0;
            underflow_o <= 1'b0;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            underflow_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    sd_o    <= 1'b0;
                    ws_o    <= 1'b0;
                    ready_o <= 1'b0;
                    busy_o  <= 1'b0;
                    if (cfg_en_i) begin
                        // Start with one silent right slot so the first sample lands on the left.
                        r_state <= ST_RUN;
                        r_len   <= w_len_cfg;
                        r_lsb   <= cfg_lsb_first_i;
                        r_cnt   <= w_len_cfg;
                        r_shift <= 32'd0;
                        ws_o    <= 1'b1;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                default: begin
                    if (w_stop) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 5'd0;
                        r_shift <= 32'd0;
                        sd_o    <= 1'b0;
                        ws_o    <= 1'b0;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end else begin
                        r_state <= cfg_en_i ? ST_RUN : ST_DRAIN;
                        ready_o <= !w_buf_valid_nxt;
                        busy_o  <= 1'b1;
                        if (w_load) begin
                            r_len       <= w_len;
                            r_lsb       <= w_lsb;
                            r_cnt       <= w_len;
                            r_shift     <= w_lsb ? (w_load_data >> 1) : (w_load_data << 1);
                            sd_o        <= w_first_bit;
                            underflow_o <= !r_buf_valid;
                        end else begin
                            sd_o    <= r_lsb ? r_shift[0] : r_shift[r_len];
                            r_shift <= r_lsb ? (r_shift >> 1) : (r_shift << 1);
                            if (r_cnt == 5'd1) begin
                                ws_o  <= !ws_o;
                                r_cnt <= 5'd0;
                            end else begin
                                r_cnt <= r_cnt - 5'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef I2S_TX_UNDERFLOW_CNT_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            underflow_cnt_o <= 16'd0;
        end else if ((r_state == ST_IDLE) && cfg_en_i) begin
            underflow_cnt_o <= 16'd0;
        end else if (w_load && !r_buf_valid && (underflow_cnt_o != 16'hFFFF)) begin
            underflow_cnt_o <= underflow_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: directed frame scenarios plus randomized traffic,
// checked against a slot-level model of the I2S output stream.
module tb_i2s_tx_serializer;

    logic        clk_i;
    logic        rstn_i;
    logic        cfg_en_i;
    logic [4:0]  cfg_word_len_i;
    logic        cfg_lsb_first_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic        sd_o;
    logic        ws_o;
    logic        underflow_o;
    logic        busy_o;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt_o;
`endif

    i2s_tx_serializer dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_word_len_i  (cfg_word_len_i),
        .cfg_lsb_first_i (cfg_lsb_first_i),
        .data_i          (data_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .sd_o            (sd_o),
        .ws_o            (ws_o),
        .underflow_o     (underflow_o),
        .busy_o          (busy_o)
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt_o (underflow_cnt_o)
`endif
    );

    // Clock and reset block
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: expected per-cycle {underflow, ws, sd} of the stream
    logic [2:0]  exp_q[$];
    logic [31:0] m_buf_q[$];
    logic [31:0] supply[$];
    logic        m_active;
    logic        m_en_prev;
    logic        m_next_ws;
    logic        m_lsb;
    int          m_len;
    int          m_uf_cnt;
    int          valid_pct;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_len(input logic [4:0] l);
        return (l < 5'd7) ? 7 : int'(l);
    endfunction

    // One slot of m_len+1 bits; ws announces the next slot on the last bit.
    task automatic push_slot(input logic [31:0] d, input logic side, input logic uf);
        logic b;
        logic w;
        for (int i = 0; i <= m_len; i++) begin
            b = m_lsb ? d[i] : d[m_len - i];
            w = (i == m_len) ? !side : side;
            exp_q.push_back({(i == 0) ? uf : 1'b0, w, b});
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_buf_q.delete();
        m_active  = 1'b0;
        m_en_prev = 1'b0;
        m_next_ws = 1'b0;
        m_lsb     = 1'b0;
        m_len     = 7;
        m_uf_cnt  = 0;
    endtask

    task automatic model_edge(input logic hs, input logic [31:0] d_in, input logic en_now,
                              input logic [4:0] len_now, input logic lsb_now);
        logic [31:0] d;
        logic        uf;
        if (!m_active) begin
            if (en_now) begin
                m_active = 1'b1;
                m_len    = clamp_len(len_now);
                m_lsb    = lsb_now;
                m_uf_cnt = 0;
                push_slot(32'd0, 1'b1, 1'b0);
                m_next_ws = 1'b0;
            end
        end else if (exp_q.size() == 0) begin
            if (!m_next_ws && !m_en_prev && !en_now) begin
                m_active = 1'b0;
                m_buf_q.delete();
            end else begin
                if (!m_next_ws) begin
                    m_len = clamp_len(len_now);
                    m_lsb = lsb_now;
                end
                if (m_buf_q.size() > 0) begin
                    d  = m_buf_q.pop_front();
                    uf = 1'b0;
                end else begin
                    d  = 32'd0;
                    uf = 1'b1;
                    if (m_uf_cnt < 65535) m_uf_cnt++;
                end
                push_slot(d, m_next_ws, uf);
                m_next_ws = !m_next_ws;
            end
        end
        if (m_active && hs) m_buf_q.push_back(d_in);
        m_en_prev = en_now;
    endtask

    // Driver: offer the head of the supply queue with probability valid_pct.
    task automatic drive_valid();
        if (supply.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
            valid_i = 1'b1;
            data_i  = supply[0];
        end else begin
            valid_i = 1'b0;
            data_i  = $urandom();
        end
    endtask

    // One clock: capture inputs, step the model, compare outputs, re-drive at negedge.
    task automatic tick();
        logic        hs;
        logic        en_now;
        logic        lsb_now;
        logic [4:0]  len_now;
        logic [31:0] d_now;
        logic [2:0]  e;
        hs      = valid_i && ready_o;
        en_now  = cfg_en_i;
        len_now = cfg_word_len_i;
        lsb_now = cfg_lsb_first_i;
        d_now   = data_i;
        @(posedge clk_i);
        #1;
        if (hs && supply.size() > 0) void'(supply.pop_front());
        model_edge(hs, d_now, en_now, len_now, lsb_now);
        e = m_active ? exp_q.pop_front() : 3'b000;
        check("sd", 32'(sd_o), 32'(e[0]));
        check("ws", 32'(ws_o), 32'(e[1]));
        check("underflow", 32'(underflow_o), 32'(e[2]));
        check("ready", 32'(ready_o), 32'(m_active && (m_buf_q.size() == 0)));
        check("busy", 32'(busy_o), 32'(m_active));
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        check("uf_cnt", 32'(underflow_cnt_o), 32'(m_uf_cnt));
`endif
        @(negedge clk_i);
        drive_valid();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sd"}, 32'(sd_o), 32'd0);
        check({tag, "_ws"}, 32'(ws_o), 32'd0);
        check({tag, "_uf"}, 32'(underflow_o), 32'd0);
        check({tag, "_ready"}, 32'(ready_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        check({tag, "_cnt"}, 32'(underflow_cnt_o), 32'd0);
`endif
    endtask

    // Mid-cycle asynchronous reset; called at a negedge.
    task automatic do_reset();
        #2;
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        drive_valid();
    endtask

    initial begin
        logic [15:0] cap16;
        logic [7:0]  cap8;
        int          n;

        rstn_i          = 1'b0;
        cfg_en_i        = 1'b0;
        cfg_word_len_i  = 5'd15;
        cfg_lsb_first_i = 1'b0;
        valid_i         = 1'b0;
        data_i          = 32'd0;
        valid_pct       = 100;
        model_reset();
        @(negedge clk_i);
        check_reset_outputs("reset");
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Two samples, 16-bit MSB-first frame after the silent right slot
        supply.push_back(32'h0000A5A5);
        supply.push_back(32'h00000F0F);
        drive_valid();
        cfg_en_i = 1'b1;
        tick();
        check("silent_first_ws", 32'(ws_o), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("silent_end_ws_edge", 32'(ws_o), 32'd0);
        cap16 = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cap16 = {cap16[14:0], sd_o};
        end
        check("left_a5a5", 32'(cap16), 32'h0000A5A5);
        check("left_end_ws_edge", 32'(ws_o), 32'd1);
        cap16 = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cap16 = {cap16[14:0], sd_o};
        end
        check("right_0f0f", 32'(cap16), 32'h00000F0F);

        // Starved slots: zeros and one underflow pulse each
        n = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (underflow_o) n++;
        end
        check("starved_pulses", 32'(n), 32'd3);
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        check("starved_count", 32'(underflow_cnt_o), 32'd3);
`endif

        // Word length change in mid right slot takes effect on the next left slot
        for (int i = 0; i < 6; i++) supply.push_back($urandom());
        for (int i = 0; i < 5; i++) tick();
        cfg_word_len_i = 5'd23;
        for (int i = 0; i < 11; i++) tick();
        n = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (ws_o) break;
            n++;
        end
        check("left_len_24", 32'(n + 1), 32'd24);

        // Drop enable three bits into a left slot: the frame completes, then idle
        for (int i = 0; i < 64; i++) begin
            tick();
            if (!ws_o) break;
        end
        for (int i = 0; i < 3; i++) tick();
        cfg_en_i = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (!busy_o) break;
        end
        check("drain_cycles", 32'(n), 32'd46);
        check("drain_ws", 32'(ws_o), 32'd0);
        for (int i = 0; i < 10; i++) tick();

        // 8-bit LSB-first slot of sample 0x01
        supply.delete();
        supply.push_back(32'h00000001);
        cfg_word_len_i  = 5'd7;
        cfg_lsb_first_i = 1'b1;
        cfg_en_i        = 1'b1;
        drive_valid();
        tick();
        for (int i = 0; i < 7; i++) tick();
        cap8 = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cap8 = {cap8[6:0], sd_o};
        end
        check("lsb_first_01", 32'(cap8), 32'h00000080);

        // Reset in the middle of a slot, then restart with a silent right slot
        supply.push_back(32'h12345678);
        for (int i = 0; i < 5; i++) tick();
        do_reset();
        tick();
        check("restart_silent_ws", 32'(ws_o), 32'd1);
        check("restart_silent_sd", 32'(sd_o), 32'd0);

        // Randomized traffic: word length, bit order, enable and valid gaps
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 99) < 10) cfg_word_len_i = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) < 5)  cfg_lsb_first_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 2)  cfg_en_i = !cfg_en_i;
            if ($urandom_range(0, 99) < 3)  valid_pct = $urandom_range(20, 100);
            if (supply.size() < 3) supply.push_back($urandom());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
